// File: rtl/pipeline_add_elastic.sv
// pipeline_add_elastic
//   Elastic adder pipeline: operand1 + operand2 (WIDTH+1-bit add, carry kept) is
//   captured in stage 0 and carried through STAGES registers, each with its own
//   valid bit. Valid/ready handshake on both sides, backpressure with bubble
//   collapsing, synchronous flush, registered occupancy count.
//
//   Optional feature macro: PIPE_ADD_SUB_EN
//     defined   -> extra input `sub`; sub=1 computes operand1 - operand2 as
//                  operand1 + ~operand2 + 1 (carry_out=1 means no borrow)
//     undefined -> add-only, no `sub` port
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous discard of all in-flight ops
//   in_valid   in   operand pair valid
//   in_ready   out  pipeline can accept this cycle (combinational from out_ready)
//   operand1   in   WIDTH  first operand
//   operand2   in   WIDTH  second operand
//   sub        in   subtract select (PIPE_ADD_SUB_EN only)
//   out_valid  out  result/carry_out valid
//   out_ready  in   consumer accepts result
//   result     out  WIDTH  sum mod 2^WIDTH
//   carry_out  out  carry out of bit WIDTH-1
//   occupancy  out  number of valid stages

module pipeline_add_elastic #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            operand1,
   input  logic [WIDTH-1:0]            operand2,
`ifdef PIPE_ADD_SUB_EN
   input  logic                        sub,
`endif
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            result,
   output logic                        carry_out,
   output logic [$clog2(STAGES+1)-1:0] occupancy
);

   localparam int LAST  = STAGES - 1;
   localparam int OCC_W = $clog2(STAGES + 1);

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic [WIDTH:0]    data_q [STAGES];
   logic [WIDTH:0]    data_d [STAGES];
   logic [OCC_W-1:0]  occupancy_q;
   logic [OCC_W-1:0]  occupancy_d;

   logic [STAGES-1:0] adv;
   logic              accept;
   logic              pop;
   logic [WIDTH:0]    sum;

   // Advance chain, evaluated from the output back towards stage 0. A stage
   // advances when it holds data and the stage below it is empty or advancing
   // itself, which is what lets bubbles collapse under backpressure.
   always_comb begin : adv_chain
      logic room;
      logic go;
      adv  = '0;
      room = out_ready;
      for (int i = LAST; i >= 0; i--) begin
         go     = v_q[i] && room;
         adv[i] = go;
         room   = !v_q[i] || go;
      end
   end

   always_comb begin : add_stage
`ifdef PIPE_ADD_SUB_EN
      sum = {1'b0, operand1} + {1'b0, (sub ? ~operand2 : operand2)}
            + {{WIDTH{1'b0}}, sub};
`else
      sum = {1'b0, operand1} + {1'b0, operand2};
`endif
   end

   // in_ready is held low during reset even though the valid bits already read 0.
   assign in_ready = !rst && !flush && (!v_q[0] || adv[0]);
   assign accept   = in_valid && in_ready;
   assign pop      = v_q[LAST] && out_ready;

   always_comb begin : next_state
      v_d = v_q;
      for (int i = 0; i < STAGES; i++) begin
         data_d[i] = data_q[i];
      end

      if (accept) begin
         v_d[0]    = 1'b1;
         data_d[0] = sum;
      end else if (adv[0]) begin
         v_d[0] = 1'b0;
      end

      // Stage i loads exactly when stage i-1 advances.
      for (int i = 1; i < STAGES; i++) begin
         if (adv[i-1]) begin
            v_d[i]    = 1'b1;
            data_d[i] = data_q[i-1];
         end else if (adv[i]) begin
            v_d[i] = 1'b0;
         end
      end

      // Flush only drops the valid bits; stale data is never observed.
      if (flush) begin
         v_d = '0;
      end
   end

   always_comb begin : occ_next
      if (flush) begin
         occupancy_d = '0;
      end else begin
         occupancy_d = occupancy_q + OCC_W'(accept) - OCC_W'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q         <= '0;
         occupancy_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         v_q         <= v_d;
         occupancy_q <= occupancy_d;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign out_valid = v_q[LAST];
   assign result    = data_q[LAST][WIDTH-1:0];
   assign carry_out = data_q[LAST][WIDTH];
   assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipeline_add_elastic.sv
// Directed bench for pipeline_add_elastic (WIDTH=32, STAGES=5).

module tb_pipeline_add_elastic;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] operand1;
   logic [31:0] operand2;
`ifdef PIPE_ADD_SUB_EN
   logic        sub;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        carry_out;
   logic [2:0]  occupancy;

   int checks = 0;
   int errors = 0;

   pipeline_add_elastic #(.WIDTH(32), .STAGES(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand1  (operand1),
      .operand2  (operand2),
`ifdef PIPE_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
      in_valid = v;
      operand1 = a;
      operand2 = b;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
`ifdef PIPE_ADD_SUB_EN
      sub       = 1'b0;
`endif
      drive(1'b0, 32'd0, 32'd0);

      // ---- reset state
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_result",    64'(result),    64'd0);
      chk("rst_carry",     64'(carry_out), 64'd0);
      #1 rst = 1'b0;

      // ---- single op, latency STAGES edges, one-cycle valid pulse
      out_ready = 1'b1;
      drive(1'b1, 32'd15, 32'd10);
      #1;
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         drive(1'b0, 32'd0, 32'd0);
         chk($sformatf("t1_out_valid_e%0d", k), 64'(out_valid), 64'(k == 5));
         if (k == 5) begin
            chk("t1_result", 64'(result),    64'd25);
            chk("t1_carry",  64'(carry_out), 64'd0);
            chk("t1_occ",    64'(occupancy), 64'd1);
         end
      end
      chk("t1_occ_end", 64'(occupancy), 64'd0);

      // ---- back-to-back stream, 1 op/cycle, in order
      for (int c = 0; c <= 12; c++) begin
         if (c < 8) drive(1'b1, 32'(c + 1), 32'(c + 1));
         else       drive(1'b0, 32'd0, 32'd0);
         tick();
         chk($sformatf("t2_valid_c%0d", c), 64'(out_valid), 64'(c >= 4 && c <= 11));
         if (c >= 4 && c <= 11)
            chk($sformatf("t2_result_c%0d", c), 64'(result), 64'(2 * (c - 3)));
      end
      drive(1'b0, 32'd0, 32'd0);

      // ---- wrap / carry
      for (int c = 0; c <= 6; c++) begin
         case (c)
            0: drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
            1: drive(1'b1, 32'h8000_0000, 32'h8000_0000);
            2: drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
            default: drive(1'b0, 32'd0, 32'd0);
         endcase
         tick();
         if (c == 4) begin
            chk("t3_wrap1_result", 64'(result), 64'd0);
            chk("t3_wrap1_carry",  64'(carry_out), 64'd1);
         end
         if (c == 5) begin
            chk("t3_wrap2_result", 64'(result), 64'd0);
            chk("t3_wrap2_carry",  64'(carry_out), 64'd1);
         end
         if (c == 6) begin
            chk("t3_wrap3_result", 64'(result), 64'h8000_0000);
            chk("t3_wrap3_carry",  64'(carry_out), 64'd0);
            chk("t3_wrap3_valid",  64'(out_valid), 64'd1);
         end
      end
      tick();
      chk("t3_drained", 64'(out_valid), 64'd0);

      // ---- backpressure: op k = (16k) + k = 17k
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 32'(16 * k), 32'(k));
         #1;
         chk($sformatf("t4_in_ready_op%0d", k), 64'(in_ready), 64'd1);
         tick();
      end
      drive(1'b1, 32'(16 * 6), 32'd6);
      #1;
      chk("t4_full_in_ready", 64'(in_ready),  64'd0);
      chk("t4_full_occ",      64'(occupancy), 64'd5);
      chk("t4_full_valid",    64'(out_valid), 64'd1);
      chk("t4_full_result",   64'(result),    64'd17);
      tick();
      tick();
      chk("t4_hold_result", 64'(result),    64'd17);
      chk("t4_hold_occ",    64'(occupancy), 64'd5);
      chk("t4_hold_ready",  64'(in_ready),  64'd0);
      out_ready = 1'b1;
      #1;
      chk("t4_release_in_ready", 64'(in_ready), 64'd1);
      for (int j = 0; j <= 5; j++) begin
         tick();
         drive(1'b0, 32'd0, 32'd0);
         chk($sformatf("t4_drain_valid_%0d", j), 64'(out_valid), 64'(j < 5));
         chk($sformatf("t4_drain_occ_%0d", j),   64'(occupancy), 64'(5 - j));
         if (j < 5)
            chk($sformatf("t4_drain_result_%0d", j), 64'(result), 64'(17 * (j + 2)));
      end

      // ---- flush with 3 ops in flight
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, 32'(100 * k), 32'd1);
         tick();
      end
      chk("t5_pre_occ", 64'(occupancy), 64'd3);
      flush = 1'b1;
      drive(1'b1, 32'd999, 32'd1);
      #1;
      chk("t5_flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0);
      chk("t5_occ_after", 64'(occupancy), 64'd0);
      chk("t5_valid_after", 64'(out_valid), 64'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("t5_no_stale_%0d", k), 64'(out_valid), 64'd0);
      end

      // ---- async reset mid-stream
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 32'(k), 32'd2);
         tick();
      end
      drive(1'b0, 32'd0, 32'd0);
      chk("t6_pre_valid", 64'(out_valid), 64'd1);
      chk("t6_pre_occ",   64'(occupancy), 64'd5);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid",    64'(out_valid), 64'd0);
      chk("t6_rst_occ",      64'(occupancy), 64'd0);
      chk("t6_rst_in_ready", 64'(in_ready),  64'd0);
      #1 rst = 1'b0;
      drive(1'b1, 32'd50, 32'd30);
      for (int k = 1; k <= 5; k++) begin
         tick();
         drive(1'b0, 32'd0, 32'd0);
         chk($sformatf("t6_valid_e%0d", k), 64'(out_valid), 64'(k == 5));
      end
      chk("t6_result", 64'(result),    64'd80);
      chk("t6_carry",  64'(carry_out), 64'd0);

`ifdef PIPE_ADD_SUB_EN
      // ---- subtract: 5 - 7
      tick();
      sub = 1'b1;
      drive(1'b1, 32'd5, 32'd7);
      tick();
      sub = 1'b0;
      drive(1'b0, 32'd0, 32'd0);
      for (int k = 0; k < 4; k++) tick();
      chk("t7_sub_valid",  64'(out_valid), 64'd1);
      chk("t7_sub_result", 64'(result),    64'hFFFF_FFFE);
      chk("t7_sub_carry",  64'(carry_out), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
